// File: rtl/reorder_sched_ctrl.sv
// Top-level sequencer/arbiter for the image-reordering accelerator.
// Hands the shared hash SRAM to host, hash engine and reorder engine in turn,
// collects the visiting order into a small FIFO and paces the reorder engine.
module reorder_sched_ctrl #(
   parameter int unsigned MAX_IMAGES = 512,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned WD_CYCLES  = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [8:0]  cfg_num_images,
   output logic        busy,
   output logic        done,
   output logic        error,
   input  logic        host_we,
   input  logic [11:0] host_addr,
   input  logic [31:0] host_wdata,
   output logic        hash_start,
   input  logic        hash_done,
   input  logic [11:0] hash_A1,
   input  logic [11:0] hash_A2,
   input  logic        hash_WEB1,
   input  logic        hash_WEB2,
   input  logic [31:0] hash_D1,
   input  logic [31:0] hash_D2,
   output logic        ro_rst,
   output logic        ro_start,
   output logic [8:0]  ro_num_images,
   input  logic [11:0] ro_A1,
   input  logic [11:0] ro_A2,
   input  logic        ro_WEB1,
   input  logic        ro_WEB2,
   input  logic [8:0]  ro_ref_idx,
   input  logic        ro_ref_done,
   input  logic [8:0]  ro_last_image,
   input  logic        ro_finish,
   output logic [11:0] mem_A1,
   output logic [11:0] mem_A2,
   output logic        mem_WEB1,
   output logic        mem_WEB2,
   output logic [31:0] mem_D1,
   output logic [31:0] mem_D2,
   output logic        ord_valid,
   input  logic        ord_ready,
   output logic [8:0]  ord_idx
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] L_DEPTH   = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] L_PAUSE   = CW'(FIFO_DEPTH - 2);
   localparam logic [15:0]   L_WD_LAST = 16'(WD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_HASH,
      S_REORDER,
      S_DRAIN
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic [8:0]     r_count;
   logic [8:0]     r_pushed;
   logic           r_error;
   logic           r_init_cnt;
   logic [15:0]    r_wd;
   logic           r_ref_q;
   logic           r_fin_q;

   logic [8:0]     r_mem [FIFO_DEPTH];
   logic [PW-1:0]  r_wr_ptr;
   logic [PW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_fifo_count;

   logic           w_cfg_ok;
   logic           w_accept;
   logic           w_bad_cfg;
   logic           w_wd_abort;
   logic           w_wd_hit;
   logic           w_push;
   logic [8:0]     w_push_data;
   logic           w_pop;
   logic           w_full;
   logic           w_wr;
   logic           w_drop;
   logic           w_ref_rise;
   logic           w_fin_rise;

   assign w_cfg_ok   = (cfg_num_images != '0) && (32'(cfg_num_images) <= MAX_IMAGES);
   assign w_wd_hit   = (r_wd == L_WD_LAST);
   // The engine holds its outputs while paused, so sampling every cycle
   // leaves the previous value unchanged across a pause and cannot re-trigger.
   assign w_ref_rise = ro_ref_done & ~r_ref_q;
   assign w_fin_rise = ro_finish & ~r_fin_q;

   assign busy          = (r_state != S_IDLE);
   assign error         = r_error;
   assign ro_rst        = (r_state == S_IDLE) || (r_state == S_INIT);
   assign ro_num_images = r_count;

   assign ord_valid = (r_fifo_count != '0);
   assign ord_idx   = r_mem[r_rd_ptr];
   assign w_pop     = ord_valid && ord_ready;
   assign w_full    = (r_fifo_count == L_DEPTH);
   assign w_wr      = w_push && (!w_full || w_pop);
   assign w_drop    = w_push && w_full && !w_pop;

   // Next-state decode, push selection and per-state control outputs
   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      w_bad_cfg   = 1'b0;
      w_wd_abort  = 1'b0;
      w_push      = 1'b0;
      w_push_data = '0;
      done        = 1'b0;
      hash_start  = 1'b0;
      ro_start    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_cfg_ok) begin
                  w_accept = 1'b1;
                  w_next   = S_INIT;
               end else begin
                  w_bad_cfg = 1'b1;
               end
            end
         end
         S_INIT: begin
            if (r_init_cnt) begin
               w_push = 1'b1;
               w_next = (r_count == 9'd1) ? S_DRAIN : S_HASH;
            end
         end
         S_HASH: begin
            hash_start = 1'b1;
            if (hash_done) begin
               w_next = S_REORDER;
            end else if (w_wd_hit) begin
               w_wd_abort = 1'b1;
               w_next     = S_IDLE;
            end
         end
         S_REORDER: begin
            ro_start = (r_fifo_count < L_PAUSE);
            if (w_fin_rise) begin
               w_push      = 1'b1;
               w_push_data = ro_last_image;
            end else if (w_ref_rise && !ro_finish) begin
               w_push      = 1'b1;
               w_push_data = ro_ref_idx;
            end
            if (w_push && ((r_pushed + 9'd1) == r_count)) begin
               w_next = S_DRAIN;
            end else if (!w_push && w_wd_hit) begin
               w_wd_abort = 1'b1;
               w_next     = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (r_fifo_count == '0) begin
               done   = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State register, run configuration and sticky error flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_error    <= 1'b0;
         r_init_cnt <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_init_cnt <= (r_state == S_INIT) && !r_init_cnt;
         if (w_accept) begin
            r_count <= cfg_num_images;
         end
         if (w_accept) begin
            r_error <= 1'b0;
         end else if (w_bad_cfg || w_wd_abort || w_drop) begin
            r_error <= 1'b1;
         end
      end
   end

   // Push counter, watchdog and engine handshake edge detectors
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pushed <= '0;
         r_wd     <= '0;
         r_ref_q  <= 1'b0;
         r_fin_q  <= 1'b0;
      end else begin
         r_ref_q <= ro_ref_done;
         r_fin_q <= ro_finish;
         if (w_accept) begin
            r_pushed <= '0;
         end else if (w_push) begin
            r_pushed <= r_pushed + 9'd1;
         end
         if ((w_next != r_state) || w_push) begin
            r_wd <= '0;
         end else if ((r_state == S_HASH) || (r_state == S_REORDER)) begin
            r_wd <= r_wd + 16'd1;
         end else begin
            r_wd <= '0;
         end
      end
   end

   // Order FIFO pointers and occupancy; flushed when a run is accepted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_fifo_count <= '0;
      end else if (w_accept) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_fifo_count <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         if (w_wr && !w_pop) begin
            r_fifo_count <= r_fifo_count + CW'(1);
         end else if (!w_wr && w_pop) begin
            r_fifo_count <= r_fifo_count - CW'(1);
         end
      end
   end

   // Order FIFO storage
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= w_push_data;
      end
   end

   // SRAM port ownership follows the registered state
   always_comb begin
      mem_A1   = '0;
      mem_A2   = '0;
      mem_WEB1 = 1'b1;
      mem_WEB2 = 1'b1;
      mem_D1   = '0;
      mem_D2   = '0;
      unique case (r_state)
         S_IDLE: begin
            mem_A1   = host_addr;
            mem_WEB1 = ~host_we;
            mem_D1   = host_wdata;
         end
         S_HASH: begin
            mem_A1   = hash_A1;
            mem_A2   = hash_A2;
            mem_WEB1 = hash_WEB1;
            mem_WEB2 = hash_WEB2;
            mem_D1   = hash_D1;
            mem_D2   = hash_D2;
         end
         S_REORDER: begin
            mem_A1   = ro_A1;
            mem_A2   = ro_A2;
            mem_WEB1 = ro_WEB1;
            mem_WEB2 = ro_WEB2;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_reorder_sched_ctrl.sv
// Directed bench for reorder_sched_ctrl with a small behavioural reorder engine.
module tb_reorder_sched_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [8:0]  cfg_num_images;
   logic        busy, done, error;
   logic        host_we;
   logic [11:0] host_addr;
   logic [31:0] host_wdata;
   logic        hash_start, hash_done;
   logic [11:0] hash_A1, hash_A2;
   logic        hash_WEB1, hash_WEB2;
   logic [31:0] hash_D1, hash_D2;
   logic        ro_rst, ro_start;
   logic [8:0]  ro_num_images;
   logic [11:0] ro_A1, ro_A2;
   logic        ro_WEB1, ro_WEB2;
   logic [8:0]  ro_ref_idx;
   logic        ro_ref_done;
   logic [8:0]  ro_last_image;
   logic        ro_finish;
   logic [11:0] mem_A1, mem_A2;
   logic        mem_WEB1, mem_WEB2;
   logic [31:0] mem_D1, mem_D2;
   logic        ord_valid, ord_ready;
   logic [8:0]  ord_idx;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Engine script (written by the stimulus while the engine is held in reset)
   logic [8:0]  eng_list [16];
   int unsigned eng_len = 0;
   int unsigned eng_pos;

   // Observed order stream and event counters
   logic [8:0]  cap [$];
   int unsigned n_done = 0;
   int unsigned n_hash = 0;
   int unsigned n_rst  = 0;

   always #5 clk = ~clk;

   // MAX_IMAGES lowered so an over-limit count fits the 9-bit config port
   reorder_sched_ctrl #(
      .MAX_IMAGES (300),
      .FIFO_DEPTH (8),
      .WD_CYCLES  (100)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .cfg_num_images(cfg_num_images),
      .busy(busy), .done(done), .error(error),
      .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .hash_start(hash_start), .hash_done(hash_done),
      .hash_A1(hash_A1), .hash_A2(hash_A2), .hash_WEB1(hash_WEB1), .hash_WEB2(hash_WEB2),
      .hash_D1(hash_D1), .hash_D2(hash_D2),
      .ro_rst(ro_rst), .ro_start(ro_start), .ro_num_images(ro_num_images),
      .ro_A1(ro_A1), .ro_A2(ro_A2), .ro_WEB1(ro_WEB1), .ro_WEB2(ro_WEB2),
      .ro_ref_idx(ro_ref_idx), .ro_ref_done(ro_ref_done),
      .ro_last_image(ro_last_image), .ro_finish(ro_finish),
      .mem_A1(mem_A1), .mem_A2(mem_A2), .mem_WEB1(mem_WEB1), .mem_WEB2(mem_WEB2),
      .mem_D1(mem_D1), .mem_D2(mem_D2),
      .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_idx(ord_idx)
   );

   // Reorder engine model: one result every other cycle while ro_start is high,
   // outputs held while paused, final entry reported through ro_finish.
   initial begin
      ro_ref_done   = 1'b0;
      ro_finish     = 1'b0;
      ro_ref_idx    = '0;
      ro_last_image = '0;
      eng_pos       = 0;
      forever begin
         @(posedge clk); #1;
         if (reset || ro_rst) begin
            ro_ref_done = 1'b0;
            ro_finish   = 1'b0;
            eng_pos     = 0;
         end else if (ro_start && !ro_finish) begin
            if (ro_ref_done) begin
               ro_ref_done = 1'b0;
            end else if (eng_pos + 1 == eng_len) begin
               ro_last_image = eng_list[eng_pos];
               ro_finish     = 1'b1;
               eng_pos++;
            end else if (eng_pos < eng_len) begin
               ro_ref_idx  = eng_list[eng_pos];
               ro_ref_done = 1'b1;
               eng_pos++;
            end
         end
      end
   end

   // Monitor sampled on the falling edge
   always @(negedge clk) begin
      if (ord_valid && ord_ready) cap.push_back(ord_idx);
      if (done) n_done++;
      if (hash_start) n_hash++;
      if (busy && ro_rst) n_rst++;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int unsigned budget, output logic got);
      got = 1'b0;
      for (int unsigned i = 0; i < budget && !got; i++) begin
         step();
         if (done) got = 1'b1;
      end
   endtask

   initial begin
      int unsigned base_cap, base_done, base_hash, base_rst, n;
      logic        got;
      logic [8:0]  exp_idx;

      reset = 1'b1; start = 1'b0; cfg_num_images = '0;
      host_we = 1'b0; host_addr = '0; host_wdata = '0;
      hash_done = 1'b0; hash_A1 = '0; hash_A2 = '0; hash_WEB1 = 1'b1; hash_WEB2 = 1'b1;
      hash_D1 = '0; hash_D2 = '0;
      ro_A1 = '0; ro_A2 = '0; ro_WEB1 = 1'b1; ro_WEB2 = 1'b1;
      ord_ready = 1'b0;
      for (int unsigned i = 0; i < 16; i++) eng_list[i] = '0;

      step(); step();
      check("rst_busy",       32'(busy), 32'd0);
      check("rst_done",       32'(done), 32'd0);
      check("rst_error",      32'(error), 32'd0);
      check("rst_hash_start", 32'(hash_start), 32'd0);
      check("rst_ro_rst",     32'(ro_rst), 32'd1);
      check("rst_ro_start",   32'(ro_start), 32'd0);
      check("rst_ord_valid",  32'(ord_valid), 32'd0);
      reset = 1'b0;
      step();

      // Zero image count is rejected
      start = 1'b1; cfg_num_images = 9'd0;
      step();
      start = 1'b0;
      check("cfg0_error", 32'(error), 32'd1);
      check("cfg0_busy",  32'(busy), 32'd0);

      // Host owns port 1 while idle
      host_we = 1'b1; host_addr = 12'h100; host_wdata = 32'hDEADBEEF;
      #1;
      check("idle_mem_A1",   32'(mem_A1), 32'h100);
      check("idle_mem_WEB1", 32'(mem_WEB1), 32'd0);
      check("idle_mem_D1",   mem_D1, 32'hDEADBEEF);
      check("idle_mem_WEB2", 32'(mem_WEB2), 32'd1);

      // Four images: engine reports 2,1 then finishes on 3
      base_cap = cap.size(); base_done = n_done; base_rst = n_rst;
      eng_list[0] = 9'd2; eng_list[1] = 9'd1; eng_list[2] = 9'd3; eng_len = 3;
      ord_ready = 1'b1; hash_A1 = 12'h055; ro_A1 = 12'h0AB;
      start = 1'b1; cfg_num_images = 9'd4;
      step();
      start = 1'b0;
      check("run4_error_clr", 32'(error), 32'd0);
      check("run4_busy",      32'(busy), 32'd1);
      check("run4_init_rst",  32'(ro_rst), 32'd1);
      check("run4_num",       32'(ro_num_images), 32'd4);
      step(); step();
      check("run4_hash_start", 32'(hash_start), 32'd1);
      check("run4_hash_rst",   32'(ro_rst), 32'd0);
      check("hash_mem_A1",     32'(mem_A1), 32'h055);
      check("hash_mem_WEB1",   32'(mem_WEB1), 32'd1);
      host_we = 1'b0;
      step(); step();
      hash_done = 1'b1;
      step();
      hash_done = 1'b0;
      check("run4_ro_start",   32'(ro_start), 32'd1);
      check("run4_hash_low",   32'(hash_start), 32'd0);
      check("reorder_mem_A1",  32'(mem_A1), 32'h0AB);
      wait_done(200, got);
      check("run4_done_seen", 32'(got), 32'd1);
      step();
      check("run4_idle",      32'(busy), 32'd0);
      check("run4_done_cnt",  n_done - base_done, 32'd1);
      check("run4_rst_cycles", n_rst - base_rst, 32'd2);
      check("run4_ord_len",   32'(cap.size() - base_cap), 32'd4);
      if (cap.size() >= base_cap + 4) begin
         check("run4_ord0", 32'(cap[base_cap + 0]), 32'd0);
         check("run4_ord1", 32'(cap[base_cap + 1]), 32'd2);
         check("run4_ord2", 32'(cap[base_cap + 2]), 32'd1);
         check("run4_ord3", 32'(cap[base_cap + 3]), 32'd3);
      end

      // Single image: no hash phase, stream {0}
      base_cap = cap.size(); base_done = n_done; base_hash = n_hash; base_rst = n_rst;
      eng_len = 0;
      start = 1'b1; cfg_num_images = 9'd1;
      step();
      start = 1'b0;
      check("run1_busy",  32'(busy), 32'd1);
      check("run1_rst_a", 32'(ro_rst), 32'd1);
      step();
      check("run1_rst_b", 32'(ro_rst), 32'd1);
      step();
      check("run1_rst_off",   32'(ro_rst), 32'd0);
      check("run1_ord_valid", 32'(ord_valid), 32'd1);
      check("run1_ord_idx",   32'(ord_idx), 32'd0);
      check("run1_no_done_yet", 32'(done), 32'd0);
      wait_done(50, got);
      check("run1_done_seen", 32'(got), 32'd1);
      step();
      check("run1_done_cnt",   n_done - base_done, 32'd1);
      check("run1_hash_never", n_hash - base_hash, 32'd0);
      check("run1_rst_cycles", n_rst - base_rst, 32'd2);
      check("run1_ord_len",    32'(cap.size() - base_cap), 32'd1);
      if (cap.size() > base_cap) check("run1_ord0", 32'(cap[base_cap]), 32'd0);

      // Sixteen images with the consumer stalled: engine must pause at six queued
      base_cap = cap.size(); base_done = n_done;
      for (int unsigned i = 0; i < 15; i++) eng_list[i] = 9'(((i * 7) % 15) + 1);
      eng_len = 15;
      ord_ready = 1'b0;
      start = 1'b1; cfg_num_images = 9'd16;
      step();
      start = 1'b0;
      step(); step(); step();
      hash_done = 1'b1;
      step();
      hash_done = 1'b0;
      got = 1'b0;
      for (int unsigned i = 0; i < 100 && !got; i++) begin
         @(posedge clk); #2;
         if (!ro_start) got = 1'b1;
      end
      check("run16_paused",       32'(got), 32'd1);
      check("run16_refs_at_pause", eng_pos, 32'd5);
      repeat (10) step();
      check("run16_still_paused", 32'(ro_start), 32'd0);
      check("run16_no_extra",     eng_pos, 32'd5);
      check("run16_head_valid",   32'(ord_valid), 32'd1);
      check("run16_head_idx",     32'(ord_idx), 32'd0);
      check("run16_none_popped",  32'(cap.size() - base_cap), 32'd0);
      check("run16_busy",         32'(busy), 32'd1);
      ord_ready = 1'b1;
      wait_done(400, got);
      check("run16_done_seen", 32'(got), 32'd1);
      step();
      check("run16_done_cnt", n_done - base_done, 32'd1);
      check("run16_error",    32'(error), 32'd0);
      check("run16_ord_len",  32'(cap.size() - base_cap), 32'd16);
      if (cap.size() >= base_cap + 16) begin
         for (int unsigned k = 0; k < 16; k++) begin
            exp_idx = (k == 0) ? 9'd0 : 9'((((k - 1) * 7) % 15) + 1);
            check($sformatf("run16_ord%0d", k), 32'(cap[base_cap + k]), 32'(exp_idx));
         end
      end

      // Count above MAX_IMAGES is rejected
      start = 1'b1; cfg_num_images = 9'd400;
      step();
      start = 1'b0;
      check("cfg400_error", 32'(error), 32'd1);
      check("cfg400_busy",  32'(busy), 32'd0);

      // Hash engine never completes: watchdog abort after 100 cycles
      base_done = n_done;
      ord_ready = 1'b0; eng_len = 0;
      start = 1'b1; cfg_num_images = 9'd4;
      step();
      start = 1'b0;
      check("wd_error_clr", 32'(error), 32'd0);
      step(); step();
      n = 0;
      while (hash_start && n < 300) begin
         n++;
         step();
      end
      check("wd_hash_cycles", n, 32'd100);
      check("wd_error",       32'(error), 32'd1);
      check("wd_idle",        32'(busy), 32'd0);
      check("wd_no_done",     n_done - base_done, 32'd0);

      // Reset in the middle of a run
      start = 1'b1; cfg_num_images = 9'd4;
      step();
      start = 1'b0;
      step(); step();
      check("mid_hash",      32'(hash_start), 32'd1);
      check("mid_ord_valid", 32'(ord_valid), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_busy",       32'(busy), 32'd0);
      check("mid_rst_hash_start", 32'(hash_start), 32'd0);
      check("mid_rst_ro_rst",     32'(ro_rst), 32'd1);
      check("mid_rst_ord_valid",  32'(ord_valid), 32'd0);
      check("mid_rst_error",      32'(error), 32'd0);
      step();
      reset = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
